// File: rtl/pbvi_pkg.sv
// PBVI backup, step 2: shared sizes, types and helpers.
// Q0.16 unsigned data throughout.
package pbvi_pkg;

  localparam int N_ACTION = 3;
  localparam int N_OBS    = 2;
  localparam int N_POINT  = 16;
  localparam int N_STATE  = 2;
  localparam int W        = 16;

  localparam int VW = N_STATE * W;
  localparam int GW = N_ACTION * N_OBS * N_POINT * VW;
  localparam int RW = N_ACTION * VW;
  localparam int BW = N_POINT * VW;
  localparam int OW = N_ACTION * N_POINT * VW;

  typedef logic [W-1:0]   val_t;
  typedef logic [2*W:0]   dot_t;
  typedef logic [W+1:0]   acc_t;
  typedef logic [VW-1:0]  vec_t;

  // Clamp a widened sum back into W bits.
  function automatic val_t sat(input acc_t x);
    if (x > acc_t'({W{1'b1}}))
      return {W{1'b1}};
    return x[W-1:0];
  endfunction

endpackage

// File: rtl/pbvi_argmax_select.sv
// Picks the alpha-vector with the largest dot product
// against one belief point; lowest index wins on ties.
import pbvi_pkg::*;

module pbvi_argmax_select (
  input  logic [VW-1:0]         i_belief,
  input  logic [N_POINT*VW-1:0] i_alpha,
  output logic [VW-1:0]         o_sel
);

  // Full-width dot products, then a heap-ordered max tree.
  // Right child only wins when strictly larger, so the
  // lower index survives every tie.
  always_comb begin
    dot_t             v_dot [2*N_POINT-1];
    vec_t             v_vec [2*N_POINT-1];
    logic [2*W-1:0]   v_a;
    logic [2*W-1:0]   v_b;
    logic [2*W-1:0]   v_p;
    dot_t             v_acc;
    for (int i = 0; i < N_POINT; i++) begin
      v_acc = '0;
      for (int s = 0; s < N_STATE; s++) begin
        v_a   = {{W{1'b0}},
                 i_alpha[(i*N_STATE+s)*W +: W]};
        v_b   = {{W{1'b0}},
                 i_belief[s*W +: W]};
        v_p   = v_a * v_b;
        v_acc = v_acc + {1'b0, v_p};
      end
      v_dot[N_POINT-1+i] = v_acc;
      v_vec[N_POINT-1+i] = i_alpha[i*VW +: VW];
    end
    for (int n = N_POINT-2; n >= 0; n--) begin
      if (v_dot[2*n+2] > v_dot[2*n+1]) begin
        v_dot[n] = v_dot[2*n+2];
        v_vec[n] = v_vec[2*n+2];
      end else begin
        v_dot[n] = v_dot[2*n+1];
        v_vec[n] = v_vec[2*n+1];
      end
    end
    o_sel = v_vec[0];
  end

endmodule

// File: rtl/pbvi_backup_select.sv
// PBVI backup step 2: per (action, belief) sum of
// reward and best projected alpha per observation.
import pbvi_pkg::*;

module pbvi_backup_select (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [GW-1:0] gamma_intermediate_action_observation_alpha,
  input  logic [RW-1:0] gamma_reward_action,
  input  logic [BW-1:0] point_belief,
  output logic [OW-1:0] gamma_action_belief,
  output logic          en_step3
);

  localparam int SW = N_ACTION * N_OBS * N_POINT * VW;

  logic [SW-1:0] w_sel;
  logic [OW-1:0] w_next;
  logic [OW-1:0] r_out;
  logic          r_en3;

  for (genvar a = 0; a < N_ACTION; a++) begin : g_a
    for (genvar o = 0; o < N_OBS; o++) begin : g_o
      for (genvar b = 0; b < N_POINT; b++) begin : g_b
        pbvi_argmax_select u_sel (
          .i_belief (point_belief[b*VW +: VW]),
          .i_alpha  (gamma_intermediate_action_observation_alpha
                     [(a*N_OBS+o)*N_POINT*VW +: N_POINT*VW]),
          .o_sel    (w_sel[((a*N_OBS+o)*N_POINT+b)*VW +: VW])
        );
      end
    end
  end

  // Reward plus selected alphas, widened then clamped.
  always_comb begin
    acc_t v_acc;
    w_next = '0;
    for (int a = 0; a < N_ACTION; a++) begin
      for (int b = 0; b < N_POINT; b++) begin
        for (int s = 0; s < N_STATE; s++) begin
          v_acc = acc_t'(gamma_reward_action
                         [(a*N_STATE+s)*W +: W]);
          for (int o = 0; o < N_OBS; o++) begin
            v_acc = v_acc + acc_t'(val_t'(w_sel
              [(((a*N_OBS+o)*N_POINT+b)*N_STATE+s)*W +: W]));
          end
          w_next[((a*N_POINT+b)*N_STATE+s)*W +: W] =
            sat(v_acc);
        end
      end
    end
  end

  // Single register stage; outputs hold while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
      r_en3 <= 1'b0;
    end else begin
      r_en3 <= en;
      if (en)
        r_out <= w_next;
    end
  end

  assign gamma_action_belief = r_out;
  assign en_step3            = r_en3;

endmodule

// File: tb/tb_pbvi_backup_select.sv
// Bench for pbvi_backup_select: directed spec vectors
// plus random inputs against an array-based model.
import pbvi_pkg::*;

module tb_pbvi_backup_select;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [GW-1:0] gv;
  logic [RW-1:0] rv;
  logic [BW-1:0] bv;
  logic [OW-1:0] ov;
  logic          en3;

  int unsigned g   [N_ACTION][N_OBS][N_POINT][N_STATE];
  int unsigned rw  [N_ACTION][N_STATE];
  int unsigned bel [N_POINT][N_STATE];

  logic [OW-1:0] exp_v;
  int            n_pass = 0;
  int            n_chk  = 0;

  always #5 clk = ~clk;

  pbvi_backup_select dut (
    .clk                                         (clk),
    .rst                                         (rst),
    .en                                          (en),
    .gamma_intermediate_action_observation_alpha (gv),
    .gamma_reward_action                         (rv),
    .point_belief                                (bv),
    .gamma_action_belief                         (ov),
    .en_step3                                    (en3)
  );

  task automatic pack();
    for (int a = 0; a < N_ACTION; a++)
      for (int o = 0; o < N_OBS; o++)
        for (int i = 0; i < N_POINT; i++)
          for (int s = 0; s < N_STATE; s++)
            gv[(((a*N_OBS+o)*N_POINT+i)*N_STATE+s)*W +: W]
              = val_t'(g[a][o][i][s]);
    for (int a = 0; a < N_ACTION; a++)
      for (int s = 0; s < N_STATE; s++)
        rv[(a*N_STATE+s)*W +: W] = val_t'(rw[a][s]);
    for (int b = 0; b < N_POINT; b++)
      for (int s = 0; s < N_STATE; s++)
        bv[(b*N_STATE+s)*W +: W] = val_t'(bel[b][s]);
  endtask

  // Reference: argmax by plain arithmetic, then clamp.
  task automatic model(output logic [OW-1:0] e);
    longint unsigned d, best_d, sum;
    int              best;
    e = '0;
    for (int a = 0; a < N_ACTION; a++)
      for (int b = 0; b < N_POINT; b++)
        for (int s = 0; s < N_STATE; s++) begin
          sum = rw[a][s];
          for (int o = 0; o < N_OBS; o++) begin
            best   = 0;
            best_d = 0;
            for (int i = 0; i < N_POINT; i++) begin
              d = 0;
              for (int k = 0; k < N_STATE; k++)
                d += longint'(g[a][o][i][k]) * bel[b][k];
              if (i == 0 || d > best_d) begin
                best   = i;
                best_d = d;
              end
            end
            sum += g[a][o][best][s];
          end
          if (sum > 65535) sum = 65535;
          e[((a*N_POINT+b)*N_STATE+s)*W +: W] = val_t'(sum);
        end
  endtask

  task automatic spec_stim();
    for (int b = 0; b < N_POINT; b++) begin
      bel[b][0] = b * 'h1000;
      bel[b][1] = 'hffff - b * 'h1000;
    end
    rw[0][0] = 7209; rw[0][1] = 0;
    rw[1][0] = 0;    rw[1][1] = 7209;
    rw[2][0] = 6488; rw[2][1] = 6488;
    for (int a = 0; a < N_ACTION; a++)
      for (int o = 0; o < N_OBS; o++)
        for (int i = 0; i < N_POINT; i++) begin
          g[a][o][i][0] = (i == 2*a+o) ? 'hffff : 1;
          g[a][o][i][1] = 0;
        end
  endtask

  function automatic int unsigned rv16(int mode);
    case (mode)
      0:       return $urandom_range(0, 2);
      1:       return $urandom_range(0, 65535);
      default: return $urandom_range(16'hf000, 16'hffff);
    endcase
  endfunction

  task automatic rand_stim();
    int m;
    m = $urandom_range(0, 2);
    for (int a = 0; a < N_ACTION; a++)
      for (int o = 0; o < N_OBS; o++)
        for (int i = 0; i < N_POINT; i++)
          for (int s = 0; s < N_STATE; s++)
            g[a][o][i][s] = rv16(m);
    for (int a = 0; a < N_ACTION; a++)
      for (int s = 0; s < N_STATE; s++)
        rw[a][s] = rv16($urandom_range(0, 2));
    for (int b = 0; b < N_POINT; b++)
      for (int s = 0; s < N_STATE; s++)
        bel[b][s] = rv16(m == 0 ? 0 : 1);
  endtask

  function automatic int unsigned el(
    input logic [OW-1:0] v, input int a, b, s);
    return v[((a*N_POINT+b)*N_STATE+s)*W +: W];
  endfunction

  task automatic chk(string tag,
                     int unsigned obs, int unsigned e);
    n_chk++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, e);
  endtask

  task automatic chk_vec(string tag,
                         logic [OW-1:0] obs,
                         logic [OW-1:0] e);
    int k;
    k = 0;
    for (int j = OW/W - 1; j >= 0; j--)
      if (obs[j*W +: W] !== e[j*W +: W]) k = j;
    n_chk++;
    assert (obs === e) n_pass++;
    else $error("FAIL %s elem %0d observed=%h expected=%h",
                tag, k, obs[k*W +: W], e[k*W +: W]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    spec_stim();
    pack();
    step();
    chk_vec("reset_out", ov, '0);
    chk("reset_en3", en3, 0);

    rst = 1'b0;
    step();
    model(exp_v);
    chk_vec("spec_all", ov, exp_v);
    chk("spec_en3", en3, 1);
    chk("a1b0_s0", el(ov, 1, 0, 0), 2);
    chk("a1b0_s1", el(ov, 1, 0, 1), 7209);
    chk("a2b8_s0", el(ov, 2, 8, 0), 16'hffff);
    chk("a2b8_s1", el(ov, 2, 8, 1), 6488);
    chk("a0b0_s0", el(ov, 0, 0, 0), 16'hffff);
    chk("a0b0_s1", el(ov, 0, 0, 1), 0);

    en = 1'b0;
    rand_stim();
    pack();
    step();
    chk("drop_en3", en3, 0);
    chk_vec("hold1", ov, exp_v);
    step();
    chk_vec("hold2", ov, exp_v);

    en = 1'b1;
    for (int t = 0; t < 30; t++) begin
      rand_stim();
      pack();
      step();
      model(exp_v);
      chk_vec("track", ov, exp_v);
      chk("track_en3", en3, 1);
    end

    rst = 1'b1;
    rand_stim();
    pack();
    step();
    exp_v = '0;
    chk_vec("mid_rst", ov, exp_v);
    chk("mid_rst_en3", en3, 0);
    rst = 1'b0;

    for (int t = 0; t < 20; t++) begin
      en = 1'($urandom_range(0, 1));
      rand_stim();
      pack();
      step();
      if (en) model(exp_v);
      chk_vec("mix", ov, exp_v);
      chk("mix_en3", en3, int'(en));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
